// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for the controller instruction memory
// Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte (CHECK state, err_code 10).
module prog_loader #(
  parameter int unsigned IMAGE_BYTES    = 20,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       prog_enable,
  output logic [7:0] prog_data,
  output logic       run,
  output logic       busy,
  output logic [1:0] err_code
);
  localparam int unsigned         IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]   IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]          LEN_BYTE = 8'(IMAGE_BYTES);
  localparam logic [7:0]          LAST_IDX = 8'(IMAGE_BYTES - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_ready;
  logic              r_run;
  logic              r_prog_en;
  logic [7:0]        r_prog_data;
  logic [1:0]        r_err;
  logic [1:0]        w_err_next;
  logic [7:0]        r_count;
  logic [IDLE_W-1:0] r_idle;
  logic [IDLE_W-1:0] w_idle_next;
  logic              w_accept;
  logic              w_in_frame;
  logic              w_timeout;
  logic              w_payload_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [1:0] ERR_SUM = 2'b10;
  logic [7:0]        r_sum;
  logic [7:0]        w_sum_check;
  assign w_sum_check = r_sum + in_data;
`endif

  assign w_accept       = in_valid && r_ready;
  assign w_payload_byte = w_accept && (r_state == S_PAYLOAD);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
`else
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD);
`endif

  always_comb begin
    w_next      = r_state;
    w_err_next  = r_err;
    w_idle_next = '0;
    w_timeout   = 1'b0;
    if (w_in_frame && !w_accept) begin
      w_idle_next = (r_idle == IDLE_MAX) ? r_idle : r_idle + 1'b1;
      w_timeout   = (w_idle_next == IDLE_MAX);
    end
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (w_accept && (in_data == MAGIC)) begin
          w_next     = S_LEN;
          w_err_next = ERR_NONE;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          if (in_data == LEN_BYTE) begin
            w_next = S_PAYLOAD;
          end else begin
            w_next     = S_ERROR;
            w_err_next = ERR_LEN;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_accept && (r_count == LAST_IDX)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_RUN;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_accept) begin
          if (w_sum_check == 8'h00) begin
            w_next = S_RUN;
          end else begin
            w_next     = S_ERROR;
            w_err_next = ERR_SUM;
          end
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
    // An accepted byte always clears the idle count, so a timeout only fires on an idle cycle.
    if (w_timeout) begin
      w_next     = S_ERROR;
      w_err_next = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_run       <= 1'b0;
      r_prog_en   <= 1'b0;
      r_prog_data <= 8'h00;
      r_err       <= ERR_NONE;
      r_count     <= 8'h00;
      r_idle      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum       <= 8'h00;
`endif
    end else begin
      r_state   <= w_next;
      r_ready   <= 1'b1;
      // Rises one cycle after RUN is entered, falls as soon as a new frame starts.
      r_run     <= (r_state == S_RUN) && (w_next == S_RUN);
      r_err     <= w_err_next;
      r_idle    <= w_idle_next;
      r_prog_en <= w_payload_byte;
      if (w_payload_byte) begin
        r_prog_data <= in_data;
      end
      if (r_state == S_LEN) begin
        r_count <= 8'h00;
      end else if (w_payload_byte) begin
        r_count <= r_count + 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (r_state == S_LEN) begin
        r_sum <= 8'h00;
      end else if (w_payload_byte) begin
        r_sum <= w_sum_check;
      end
`endif
    end
  end

  assign in_ready    = r_ready;
  assign prog_enable = r_prog_en;
  assign prog_data   = r_prog_data;
  assign run         = r_run;
  assign busy        = w_in_frame;
  assign err_code    = r_err;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
// Honours PROG_LOADER_CHECKSUM_EN the same way as the design.
module tb_prog_loader;
  localparam int unsigned IMG = 4;
  localparam logic [7:0]  MAG = 8'hA5;
  localparam int unsigned TO  = 8;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int FRAME_LEN = IMG + 2 + (CHK ? 1 : 0);

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       prog_enable;
  logic [7:0] prog_data;
  logic       run;
  logic       busy;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  prog_loader #(.IMAGE_BYTES(IMG), .MAGIC(MAG), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .prog_enable(prog_enable), .prog_data(prog_data),
    .run(run), .busy(busy), .err_code(err_code)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame bytes collected in a queue, outcome judged when the frame is complete.
  logic [7:0] mq[$];
  bit         m_in_frame = 1'b0;
  bit         m_loaded = 1'b0;
  int         m_idle = 0;
  logic       e_ready = 1'b0, e_pe = 1'b0, e_run = 1'b0, e_busy = 1'b0;
  logic [7:0] e_pd = 8'h00;
  logic [1:0] e_err = 2'd0;

  task automatic model_step(input bit rst, input bit v, input logic [7:0] d);
    bit acc, was_loaded;
    int n;
    logic [7:0] s;
    if (!rst) begin
      mq.delete();
      m_in_frame = 0; m_loaded = 0; m_idle = 0;
      e_ready = 0; e_pe = 0; e_pd = 8'h00; e_run = 0; e_busy = 0; e_err = 2'd0;
      return;
    end
    acc = v && e_ready;
    was_loaded = m_loaded;
    e_pe = 0;
    if (!m_in_frame) begin
      if (acc && d == MAG) begin
        mq.delete(); mq.push_back(d);
        m_in_frame = 1; m_loaded = 0; m_idle = 0; e_err = 2'd0;
      end
    end else if (acc) begin
      mq.push_back(d);
      m_idle = 0;
      n = mq.size();
      if (n == 2 && d != 8'(IMG)) begin
        m_in_frame = 0; e_err = 2'd1;
      end else if (n >= 3 && n <= IMG + 2) begin
        e_pe = 1; e_pd = d;
      end
      if (m_in_frame && n == FRAME_LEN) begin
        s = 8'h00;
        foreach (mq[i]) if (i >= 2) s = s + mq[i];
        m_in_frame = 0;
        if (CHK && s != 8'h00) e_err = 2'd2;
        else m_loaded = 1;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_in_frame = 0; e_err = 2'd3;
      end
    end
    e_ready = 1;
    e_busy = m_in_frame;
    e_run = m_loaded && was_loaded;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".in_ready"}, in_ready, e_ready);
    check({tag, ".prog_enable"}, prog_enable, e_pe);
    check({tag, ".prog_data"}, prog_data, e_pd);
    check({tag, ".run"}, run, e_run);
    check({tag, ".busy"}, busy, e_busy);
    check({tag, ".err_code"}, err_code, e_err);
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [7:0] d, input bit cmp);
    rst_n = rst; in_valid = v; in_data = d;
    model_step(rst, v, d);
    @(posedge clock);
    #1;
    if (cmp) compare_all("model");
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, 1'b1, b, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_good_frame();
    send(MAG); send(8'h04); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    if (CHK) send(8'h56);
  endtask

  typedef struct {
    bit rst; bit v; logic [7:0] d;
    logic rdy; logic pe; logic [7:0] pd; logic run; logic busy; logic [1:0] err;
  } vec_t;

  function automatic vec_t vec(bit rst, bit v, logic [7:0] d, logic rdy, logic pe,
                               logic [7:0] pd, logic r, logic b, logic [1:0] e);
    vec_t x;
    x.rst = rst; x.v = v; x.d = d; x.rdy = rdy; x.pe = pe; x.pd = pd;
    x.run = r; x.busy = b; x.err = e;
    return x;
  endfunction

  task automatic run_random(input int frames);
    for (int f = 0; f < frames; f++) begin
      int mode = $urandom_range(0, 9);
      int bad_pos = $urandom_range(1, FRAME_LEN - 1);
      logic [7:0] fr[$];
      logic [7:0] sum = 8'h00;
      logic [7:0] b;
      for (int g = $urandom_range(0, 2); g > 0; g--) send(8'($urandom_range(0, 255)));
      fr.push_back(MAG);
      fr.push_back(mode == 1 ? 8'(IMG + 1 + $urandom_range(0, 200)) : 8'(IMG));
      for (int i = 0; i < IMG; i++) begin
        b = ($urandom_range(0, 7) == 0) ? MAG : 8'($urandom_range(0, 255));
        fr.push_back(b);
        sum = sum + b;
      end
      if (CHK) fr.push_back((mode == 2) ? 8'h01 - sum : 8'h00 - sum);
      for (int i = 0; i < fr.size(); i++) begin
        if (mode == 3 && i == bad_pos) idle(TO + $urandom_range(0, 1) - 1);
        else idle($urandom_range(0, 2));
        if (mode == 4 && i == bad_pos) cycle(1'b0, 1'b1, fr[i], 1'b1);
        else send(fr[i]);
      end
      idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    vec_t tbl[$];
    tbl.push_back(vec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2'd0));
    tbl.push_back(vec(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 2'd0));
    tbl.push_back(vec(1, 1, 8'hA5, 1, 0, 8'h00, 0, 1, 2'd0));
    tbl.push_back(vec(1, 1, 8'h04, 1, 0, 8'h00, 0, 1, 2'd0));
    tbl.push_back(vec(1, 1, 8'h11, 1, 1, 8'h11, 0, 1, 2'd0));
    tbl.push_back(vec(1, 1, 8'h22, 1, 1, 8'h22, 0, 1, 2'd0));
    tbl.push_back(vec(1, 1, 8'h33, 1, 1, 8'h33, 0, 1, 2'd0));
`ifdef PROG_LOADER_CHECKSUM_EN
    tbl.push_back(vec(1, 1, 8'h44, 1, 1, 8'h44, 0, 1, 2'd0));
    tbl.push_back(vec(1, 1, 8'h56, 1, 0, 8'h44, 0, 0, 2'd0));
`else
    tbl.push_back(vec(1, 1, 8'h44, 1, 1, 8'h44, 0, 0, 2'd0));
`endif
    tbl.push_back(vec(1, 0, 8'h00, 1, 0, 8'h44, 1, 0, 2'd0));
    tbl.push_back(vec(1, 0, 8'h00, 1, 0, 8'h44, 1, 0, 2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].d, 1'b0);
      check($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].rdy);
      check($sformatf("tbl%0d.prog_enable", i), prog_enable, tbl[i].pe);
      if (tbl[i].pe || !tbl[i].rst) check($sformatf("tbl%0d.prog_data", i), prog_data, tbl[i].pd);
      check($sformatf("tbl%0d.run", i), run, tbl[i].run);
      check($sformatf("tbl%0d.busy", i), busy, tbl[i].busy);
      check($sformatf("tbl%0d.err_code", i), err_code, tbl[i].err);
    end

    // Bad checksum, then recovery with a valid frame.
    if (CHK) begin
      send(MAG);
      check("restart_run_low", run, 1'b0);
      check("restart_busy", busy, 1'b1);
      send(8'h04); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h57);
      check("bad_sum_err", err_code, 2'd2);
      idle(2);
      check("bad_sum_run", run, 1'b0);
      send_good_frame();
      idle(2);
      check("recover_run", run, 1'b1);
      check("recover_err", err_code, 2'd0);
    end

    // Wrong length, ignored byte in ERROR, restart.
    send(MAG); send(8'h05);
    check("bad_len_err", err_code, 2'd1);
    check("bad_len_pe", prog_enable, 1'b0);
    send(8'h33);
    check("err_ignore_busy", busy, 1'b0);
    check("err_ignore_err", err_code, 2'd1);
    send(MAG);
    check("err_restart_busy", busy, 1'b1);
    idle(TO);
    check("len_timeout_err", err_code, 2'd3);

    // Timeout on the TO-th idle cycle; a byte on that cycle avoids it.
    send(MAG); send(8'h04); send(8'h11);
    idle(TO - 1);
    check("pre_timeout_err", err_code, 2'd0);
    check("pre_timeout_busy", busy, 1'b1);
    idle(1);
    check("timeout_err", err_code, 2'd3);
    check("timeout_busy", busy, 1'b0);
    send(MAG); send(8'h04); send(8'h11);
    idle(TO - 1);
    send(8'h22);
    check("edge_byte_err", err_code, 2'd0);
    check("edge_byte_pe", prog_enable, 1'b1);
    check("edge_byte_pd", prog_data, 8'h22);
    send(8'h33); send(8'h44);
    if (CHK) send(8'h56);
    idle(2);
    check("edge_frame_run", run, 1'b1);

    // New frame while running, then reset mid-payload.
    send(MAG);
    check("run_drop", run, 1'b0);
    check("run_drop_busy", busy, 1'b1);
    send(8'h04); send(8'h11);
    cycle(1'b0, 1'b1, 8'h22, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_pe", prog_enable, 1'b0);
    check("rst_pd", prog_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_code, 2'd0);
    check("rst_run", run, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    send(8'h33); send(8'h44);
    check("post_rst_pe", prog_enable, 1'b0);
    send_good_frame();
    idle(2);
    check("post_rst_run", run, 1'b1);

    run_random(150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Framed byte-stream loader that programs the FSM controller's instruction memory.
- Accepts a stream of bytes on a valid/ready handshake and checks the frame header and length.
- Forwards the payload bytes one per cycle onto the controller's prog_enable/prog_data pins.
- Grants the controller permission to run (run) only after a complete, valid image has been loaded.

Parameters:
- IMAGE_BYTES, 20: exact payload byte count the instruction memory expects; range 1..255.
- MAGIC, 8'hA5: frame start byte.
- TIMEOUT_CYCLES, 1023: maximum idle cycles allowed between bytes inside a frame.

Ports:
- clock  input  1  system clock.
- rst_n  input  1  reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  frame byte.
- in_ready  output  1  loader accepts in_data this cycle.
- prog_enable  output  1  high for exactly one cycle per forwarded payload byte.
- prog_data  output  8  payload byte, valid while prog_enable is high.
- run  output  1  controller may execute; low while loading, after an error, and after reset.
- busy  output  1  a frame is in progress.
- err_code  output  2  00 none, 01 bad length, 10 bad checksum, 11 timeout.

Interface decision: reset rst_n, synchronous, active-low; clock clock.

Behaviour:
- Reset values:
  - state IDLE.
  - prog_enable=0, prog_data=0, run=0, busy=0, err_code=00.
  - in_ready=0 during the reset cycle; in_ready=1 in every other cycle.
- Accept: a byte is accepted when in_valid && in_ready. Every accepted byte is consumed; there is no back-pressure after reset.
- States:
  - IDLE, RUN, ERROR:
    - An accepted byte equal to MAGIC goes to LEN, clears err_code and drops run in the same cycle the byte is accepted (run=0 the next cycle).
    - Any other byte is ignored.
  - LEN:
    - An accepted byte equal to IMAGE_BYTES goes to PAYLOAD, clears the payload counter and clears the checksum accumulator.
    - Any other value goes to ERROR with err_code=01.
  - PAYLOAD:
    - Each accepted byte is registered. prog_enable=1 and prog_data=byte in the following cycle (latency 1).
    - The payload counter increments per byte; the checksum adds the byte modulo 256.
    - After byte number IMAGE_BYTES, go to CHECK when checksum is compiled in, otherwise to RUN.
  - CHECK:
    - If the accepted byte plus the accumulator equals 0 (mod 256), go to RUN.
    - Otherwise go to ERROR with err_code=10.
  - RUN: run=1 from the cycle after the entering transition.
- busy=1 exactly in LEN, PAYLOAD and CHECK.
- Timeout:
  - In LEN, PAYLOAD and CHECK, an idle counter clears on every accepted byte and increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES, go to ERROR with err_code=11.
  - The counter is held at 0 in IDLE, RUN and ERROR.
- MAGIC inside a frame: a MAGIC byte arriving in LEN, PAYLOAD or CHECK is treated as data; there is no resynchronisation mid-frame.
- Partial image: an error after a partial load leaves the instruction memory partially written. run stays 0 until a full valid frame completes.
- Simultaneous events: a byte accepted in the same cycle the timeout count is reached takes priority; it is processed and the counter clears.
- Reset mid-frame: the loader returns to IDLE immediately with run=0. A prog_enable pulse pending from the previous cycle is dropped.
- Counter widths:
  - payload counter: 8 bits.
  - idle counter: $clog2(TIMEOUT_CYCLES+1) bits, saturating at TIMEOUT_CYCLES.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: the frame is MAGIC, LEN, IMAGE_BYTES payload bytes, then one checksum byte, with the CHECK state and err_code 10 as described above.
- Undefined:
  - The frame has no checksum byte; the last payload byte goes straight to RUN.
  - The CHECK state and the accumulator are removed.
  - err_code 10 never occurs.

Test Plan:
- IMAGE_BYTES=4, CHECKSUM_EN defined: stream A5,04,11,22,33,44,56 back-to-back -> prog_enable pulses on 4 consecutive cycles carrying 11,22,33,44; run=1 two cycles after 56 is accepted; err_code=00.
- Same stream with checksum 57 -> ERROR, err_code=10, run stays 0; then resend the valid frame -> run=1 and err_code=00.
- A5,05 -> err_code=01, no prog_enable pulses; byte 33 in ERROR is ignored; A5 restarts the loader (busy=1).
- TIMEOUT_CYCLES=8: A5,04,11 then in_valid=0 -> err_code=11 on the 8th idle cycle; a byte arriving exactly on the 8th cycle avoids the timeout.
- While run=1: send A5 -> run=0 the next cycle and busy=1; assert rst_n=0 mid-payload -> all outputs return to reset values, and the next prog_enable pulse appears only after a new frame.
- CHECKSUM_EN undefined: A5,04,11,22,33,44 -> run=1 two cycles after 44 is accepted; err_code never equals 10.
